// File: rtl/reflet_float_div.sv
`default_nettype none
// ============================================================================
// reflet_float_div : iterative restoring floating-point divider, one quotient bit per cycle
// Revision 1.0
// ============================================================================
module reflet_float_div #(
   parameter int float_size = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [float_size-1:0] in1,
   input  logic [float_size-1:0] in2,
   output logic                  busy,
   output logic                  done,
   output logic [float_size-1:0] quot
);

   function automatic int mantissa_size(input int fs);
      if (fs == 16)       return 10;
      else if (fs == 64)  return 52;
      else if (fs == 128) return 112;
      else                return 23;
   endfunction

   function automatic int exponent_size(input int fs);
      return fs - mantissa_size(fs) - 1;
   endfunction

   function automatic int exponent_bias(input int fs);
      return (1 << (exponent_size(fs) - 1)) - 1;
   endfunction

   localparam int M  = mantissa_size(float_size);
   localparam int E  = exponent_size(float_size);
   localparam int B  = exponent_bias(float_size);
   localparam int CW = $clog2(M + 3);

   localparam logic [E-1:0]  C_BIAS  = E'(B);
   localparam logic [E-1:0]  C_E_ONE = E'(1);
   localparam logic [CW-1:0] C_CNT_LOAD = CW'(M + 2);
   localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      NORM = 2'd2
   } state_t;

   state_t                state_q,  state_d;
   logic                  sign_q,   sign_d;
   logic [E-1:0]          exp_q,    exp_d;
   logic [M+1:0]          rem_q,    rem_d;
   logic [M:0]            dvs_q,    dvs_d;
   logic [M+1:0]          qt_q,     qt_d;
   logic [CW-1:0]         cnt_q,    cnt_d;
   logic                  dz_q,     dz_d;
   logic                  nz_q,     nz_d;
   logic                  busy_q,   busy_d;
   logic                  done_q,   done_d;
   logic [float_size-1:0] quot_q,   quot_d;

   logic                  w_ge;
   logic [M:0]            w_sub;
   logic [M-1:0]          w_mant;
   logic [E-1:0]          w_exp;

   // Whenever rem >= dvs the difference is below dvs, so M+1 bits hold it exactly.
   assign w_ge   = (rem_q >= {1'b0, dvs_q});
   assign w_sub  = rem_q[M:0] - dvs_q;
   assign w_mant = qt_q[M+1] ? qt_q[M:1] : qt_q[M-1:0];
   assign w_exp  = qt_q[M+1] ? exp_q : (exp_q - C_E_ONE);

   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      exp_d   = exp_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      qt_d    = qt_q;
      cnt_d   = cnt_q;
      dz_d    = dz_q;
      nz_d    = nz_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      quot_d  = quot_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               sign_d  = in1[float_size-1] ^ in2[float_size-1];
               exp_d   = in1[float_size-2:M] - in2[float_size-2:M] + C_BIAS;
               rem_d   = {2'b01, in1[M-1:0]};
               dvs_d   = {1'b1, in2[M-1:0]};
               qt_d    = '0;
               cnt_d   = C_CNT_LOAD;
               dz_d    = (in2[float_size-2:M] == '0);
               nz_d    = (in1[float_size-2:M] == '0);
               busy_d  = 1'b1;
               state_d = DIV;
            end
         end
         DIV: begin
            if (w_ge) begin
               qt_d  = {qt_q[M:0], 1'b1};
               rem_d = {w_sub, 1'b0};
            end else begin
               qt_d  = {qt_q[M:0], 1'b0};
               rem_d = {rem_q[M:0], 1'b0};
            end
            cnt_d = cnt_q - C_CNT_ONE;
            if (cnt_q == C_CNT_ONE) begin
               state_d = NORM;
            end
         end
         NORM: begin
            if (dz_q) begin
               quot_d = {sign_q, {E{1'b1}}, {M{1'b0}}};
            end else if (nz_q) begin
               quot_d = {sign_q, {(float_size-1){1'b0}}};
            end else begin
               quot_d = {sign_q, w_exp, w_mant};
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         sign_q  <= 1'b0;
         exp_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         qt_q    <= '0;
         cnt_q   <= '0;
         dz_q    <= 1'b0;
         nz_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quot_q  <= '0;
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         exp_q   <= exp_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         qt_q    <= qt_d;
         cnt_q   <= cnt_d;
         dz_q    <= dz_d;
         nz_q    <= nz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         quot_q  <= quot_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign quot = quot_q;

endmodule
`default_nettype wire

// File: tb/tb_reflet_float_div.sv
`default_nettype none
// Testbench for reflet_float_div: scoreboarded division results, latency, handshake and reset abort.
module tb_reflet_float_div;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] in1;
   logic [31:0] in2;
   logic        busy;
   logic        done;
   logic [31:0] quot;

   int          passed = 0;
   int          total  = 0;
   logic [31:0] sb [$];

   reflet_float_div #(.float_size(32)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .in1   (in1),
      .in2   (in2),
      .busy  (busy),
      .done  (done),
      .quot  (quot)
   );

   always #5 clk = ~clk;

   // Drive a start for one edge; inputs are scrambled afterwards to show they are not re-read.
   task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
      in1   = a;
      in2   = b;
      start = 1'b1;
      sb.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
      in1   = $urandom;
      in2   = $urandom;
   endtask

   // n counts edges after the start edge; returns at the negedge of the done cycle.
   task automatic wait_done(input int n0, output int n, output bit busy_ok, output bit ok);
      n       = n0;
      busy_ok = 1'b1;
      ok      = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
         if (!busy) busy_ok = 1'b0;
         n++;
      end
   endtask

   function automatic logic [31:0] pop_exp();
      if (sb.size() == 0) return 32'hxxxxxxxx;
      return sb.pop_front();
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      start = 1'b0;
      in1   = '0;
      in2   = '0;
      #12;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
      total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
      total++; if (quot !== 32'h0) $display("FAIL reset_quot: got %h expected 00000000", quot); else passed++;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_divide();
      logic [31:0] ta [3] = '{32'h40C00000, 32'h3F800000, 32'hBFC00000};
      logic [31:0] tb [3] = '{32'h40000000, 32'h40400000, 32'h3F000000};
      logic [31:0] te [3] = '{32'h40400000, 32'h3EAAAAAA, 32'hC0400000};
      int n; bit bok; bit ok; logic [31:0] e;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         launch(ta[i], tb[i], te[i]);
         wait_done(0, n, bok, ok);
         e = pop_exp();
         total++; if (!ok) $display("FAIL div_timeout[%0d]: no done within bound", i); else passed++;
         total++; if (n !== 26) $display("FAIL div_latency[%0d]: got %0d expected 26", i, n); else passed++;
         total++; if (!bok) $display("FAIL div_busy_held[%0d]: busy dropped before done", i); else passed++;
         total++; if (busy !== 1'b0) $display("FAIL div_busy_in_done[%0d]: got %b expected 0", i, busy); else passed++;
         total++; if (quot !== e) $display("FAIL div_quot[%0d]: got %h expected %h", i, quot, e); else passed++;
         @(negedge clk);
         total++; if (done !== 1'b0) $display("FAIL div_done_pulse[%0d]: got %b expected 0", i, done); else passed++;
         total++; if (quot !== e) $display("FAIL div_quot_hold[%0d]: got %h expected %h", i, quot, e); else passed++;
      end
   endtask

   task automatic test_special();
      logic [31:0] ta [3] = '{32'h3F800000, 32'h00000000, 32'h00000000};
      logic [31:0] tb [3] = '{32'h80000000, 32'h40000000, 32'h00000000};
      logic [31:0] te [3] = '{32'hFF800000, 32'h00000000, 32'h7F800000};
      int n; bit bok; bit ok; logic [31:0] e;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         launch(ta[i], tb[i], te[i]);
         wait_done(0, n, bok, ok);
         e = pop_exp();
         total++; if (!ok) $display("FAIL spec_timeout[%0d]: no done within bound", i); else passed++;
         total++; if (n !== 26) $display("FAIL spec_latency[%0d]: got %0d expected 26", i, n); else passed++;
         total++; if (quot !== e) $display("FAIL spec_quot[%0d]: got %h expected %h", i, quot, e); else passed++;
      end
   endtask

   task automatic test_back_to_back();
      int n; bit bok; bit ok; logic [31:0] e;
      @(negedge clk);
      launch(32'h40C00000, 32'h40000000, 32'h40400000);
      repeat (4) @(posedge clk);
      #1;
      in1   = 32'h3F800000;
      in2   = 32'h40400000;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(5, n, bok, ok);
      e = pop_exp();
      total++; if (n !== 26) $display("FAIL ignore_latency: got %0d expected 26", n); else passed++;
      total++; if (quot !== e) $display("FAIL ignore_quot: got %h expected %h", quot, e); else passed++;
      // Start in the done cycle itself.
      launch(32'h3F800000, 32'h40400000, 32'h3EAAAAAA);
      wait_done(0, n, bok, ok);
      e = pop_exp();
      total++; if (n !== 26) $display("FAIL b2b_latency: got %0d expected 26", n); else passed++;
      total++; if (!bok) $display("FAIL b2b_busy_held: busy dropped before done"); else passed++;
      total++; if (quot !== e) $display("FAIL b2b_quot: got %h expected %h", quot, e); else passed++;
   endtask

   task automatic test_reset_abort();
      int n; bit bok; bit ok; bit seen; logic [31:0] e;
      @(negedge clk);
      launch(32'h40C00000, 32'h40000000, 32'h40400000);
      void'(sb.pop_back());
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else passed++;
      total++; if (done !== 1'b0) $display("FAIL abort_done: got %b expected 0", done); else passed++;
      total++; if (quot !== 32'h0) $display("FAIL abort_quot: got %h expected 00000000", quot); else passed++;
      @(posedge clk);
      #1;
      reset = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) $display("FAIL abort_no_done: got activity %b expected 0", seen); else passed++;
      launch(32'h41200000, 32'h40A00000, 32'h40000000);
      wait_done(0, n, bok, ok);
      e = pop_exp();
      total++; if (n !== 26) $display("FAIL after_abort_latency: got %0d expected 26", n); else passed++;
      total++; if (quot !== e) $display("FAIL after_abort_quot: got %h expected %h", quot, e); else passed++;
   endtask

   initial begin
      test_reset();
      test_divide();
      test_special();
      test_back_to_back();
      test_reset_abort();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
